// File: rtl/planificador_llamadas_if.sv
// Call/status bundle for the four-floor elevator scheduler.
// The testbench or hall controller drives the master side; the scheduler is the slave.
interface planificador_llamadas_if;
  logic [3:0] car_req;
  logic [2:0] up_req;
  logic [2:0] dn_req;
  logic [1:0] piso;
  logic [1:0] accion;
  logic       puertas;
  logic [3:0] pending;
  logic       busy;

  modport master (output car_req, up_req, dn_req,
                  input  piso, accion, puertas, pending, busy);
  modport slave  (input  car_req, up_req, dn_req,
                  output piso, accion, puertas, pending, busy);
endinterface

// File: rtl/planificador_llamadas.sv
// Four-floor elevator call scheduler: latches calls, moves one floor per TRAVEL_TICKS ticks.
// Optional macro DOOR_HOLD_EN: a call at the current floor while doors are open restarts the door timer.
module planificador_llamadas #(
  parameter int TICK_CYCLES  = 100000000,
  parameter int TRAVEL_TICKS = 2,
  parameter int DOOR_TICKS   = 3
) (
  input  logic clk,
  input  logic rst,
  planificador_llamadas_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR_OPEN} state_t;

  localparam int TW   = $clog2(TICK_CYCLES + 1);
  localparam int MAXT = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int MW   = $clog2(MAXT + 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_CYCLES - 1);
  localparam logic [MW-1:0] TRAVEL_LAST = MW'(TRAVEL_TICKS - 1);
  localparam logic [MW-1:0] DOOR_LAST   = MW'(DOOR_TICKS - 1);

  state_t        state_q, state_d;
  logic [1:0]    piso_q, piso_d;
  logic [3:0]    pending_q, pending_d;
  logic          last_up_q, last_up_d;
  logic [MW-1:0] tmr_q, tmr_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]    accion_q, accion_d;
  logic          puertas_q, puertas_d;
  logic          busy_q, busy_d;

  logic       tick, hold, open_en;
  logic [1:0] open_floor, piso_nx;
  logic [3:0] req, set_mask;

  function automatic logic calls_above(input logic [3:0] p, input logic [1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) if (2'(i) > f) r = r | p[i];
    return r;
  endfunction

  function automatic logic calls_below(input logic [3:0] p, input logic [1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) if (2'(i) < f) r = r | p[i];
    return r;
  endfunction

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    // Hall buttons are offset: up covers floors 1..3, down covers floors 2..4.
    req = {bus.car_req[3] | bus.dn_req[2],
           bus.car_req[2] | bus.up_req[2] | bus.dn_req[1],
           bus.car_req[1] | bus.up_req[1] | bus.dn_req[0],
           bus.car_req[0] | bus.up_req[0]};
    hold = 1'b0;
`ifdef DOOR_HOLD_EN
    hold = (state_q == DOOR_OPEN) && req[piso_q];
`endif
    state_d    = state_q;
    piso_d     = piso_q;
    last_up_d  = last_up_q;
    tmr_d      = tmr_q;
    open_en    = 1'b0;
    open_floor = piso_q;
    piso_nx    = (state_q == MOVE_DN) ? piso_q - 2'd1 : piso_q + 2'd1;

    case (state_q)
      IDLE: begin
        if (pending_q[piso_q]) begin
          open_en = 1'b1;
        end else if (calls_above(pending_q, piso_q) &&
                     (last_up_q || !calls_below(pending_q, piso_q))) begin
          state_d   = MOVE_UP;
          last_up_d = 1'b1;
          tmr_d     = '0;
        end else if (calls_below(pending_q, piso_q)) begin
          state_d   = MOVE_DN;
          last_up_d = 1'b0;
          tmr_d     = '0;
        end
      end
      MOVE_UP, MOVE_DN: begin
        if (tick) begin
          if (tmr_q == TRAVEL_LAST) begin
            piso_d = piso_nx;
            tmr_d  = '0;
            if (pending_q[piso_nx]) begin
              open_en    = 1'b1;
              open_floor = piso_nx;
            end else if (!((state_q == MOVE_UP) ? calls_above(pending_q, piso_nx)
                                                 : calls_below(pending_q, piso_nx))) begin
              state_d = IDLE;
            end
          end else begin
            tmr_d = tmr_q + MW'(1);
          end
        end
      end
      DOOR_OPEN: begin
        if (hold) begin
          tmr_d = '0;
        end else if (tick) begin
          if (tmr_q == DOOR_LAST) begin
            state_d = IDLE;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + MW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (open_en) begin
      state_d = DOOR_OPEN;
      tmr_d   = '0;
    end

    // A call landing on the same edge the floor is served stays latched.
    set_mask = req;
    if (hold) set_mask[piso_q] = 1'b0;
    pending_d = pending_q | set_mask;
    if (open_en) pending_d[open_floor] = req[open_floor];

    accion_d  = (state_d == MOVE_UP) ? 2'd1 : (state_d == MOVE_DN) ? 2'd2 : 2'd0;
    puertas_d = (state_d == DOOR_OPEN);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      piso_q     <= 2'd0;
      pending_q  <= 4'd0;
      last_up_q  <= 1'b1;
      tmr_q      <= '0;
      tick_cnt_q <= '0;
      accion_q   <= 2'd0;
      puertas_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      piso_q     <= piso_d;
      pending_q  <= pending_d;
      last_up_q  <= last_up_d;
      tmr_q      <= tmr_d;
      tick_cnt_q <= tick_cnt_d;
      accion_q   <= accion_d;
      puertas_q  <= puertas_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.piso    = piso_q;
  assign bus.accion  = accion_q;
  assign bus.puertas = puertas_q;
  assign bus.pending = pending_q;
  assign bus.busy    = busy_q;
endmodule
